// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
//   Shared types and default parameter values for the run controller.
//   run_state_t  : controller FSM states
//   DEF_*        : default values for the run_ctrl parameters
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int DEF_N_CORES     = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear and count enable.
//   Clear has priority over enable.
//   After reaching all-ones, the counter holds that value until it is cleared.
// Ports
//   clk     in  1  clock, rising edge
//   reset   in  1  asynchronous reset, active-low
//   clear   in  1  synchronous clear to zero
//   enable  in  1  increment by one this cycle
//   count   out W  current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl
//   Run controller for the vector CPU array.
//   A host start edge launches the enabled cores with a one-cycle pulse.
//   The controller then collects per-core EndFlags into a sticky mask and counts RUN cycles.
//   It reports done, or timeout, to the host.
//   Optional feature macro: RUN_CTRL_PERCORE_CNT_EN adds the core_cycles output,
//   which gives the per-core cycle count up to each core's first recorded end.
// Ports
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous reset, active-low
//   start        in   1        host start level; a rising edge requests a run
//   core_enable  in   N_CORES  cores taking part in the run, sampled on the start edge
//   core_start   out  N_CORES  one-cycle launch pulse per enabled core
//   core_end     in   N_CORES  per-core EndFlag (level or pulse)
//   busy         out  1        high in LAUNCH and RUN
//   done         out  1        high in DONE
//   timeout      out  1        high in TIMEOUT
//   done_mask    out  N_CORES  sticky per-core completion flags
//   cycle_count  out  CNT_W    RUN cycles elapsed; frozen after the run ends
//   core_cycles  out  N_CORES x CNT_W  (macro build only) per-core cycle counts
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int N_CORES     = DEF_N_CORES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_CORES-1:0] core_enable,
    output logic [N_CORES-1:0] core_start,
    input  logic [N_CORES-1:0] core_end,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [N_CORES-1:0] done_mask,
`ifdef RUN_CTRL_PERCORE_CNT_EN
    output logic [CNT_W-1:0]   core_cycles [N_CORES],
`endif
    output logic [CNT_W-1:0]   cycle_count
);

    run_state_t         state, state_n;
    logic               start_q;
    logic [N_CORES-1:0] en_q, en_n;
    logic [N_CORES-1:0] mask_n;
    logic               cnt_clear, cnt_en;
    logic               start_edge, launch_go;
    logic [CNT_W-1:0]   cnt_inc;
    logic [N_CORES-1:0] mask_hit;
    logic               timeout_hit;

    // A start level held high only launches once.
    // start_q follows start every cycle, so only a 0->1 change is seen as an edge.
    assign start_edge = start & ~start_q;
    assign launch_go  = start_edge && (core_enable != '0) &&
                        ((state == IDLE) || (state == DONE) || (state == TIMEOUT));

    // Completion and timeout are decided on the value the counter will hold after this cycle.
    // Because of that, the completing cycle is already counted.
    assign cnt_inc     = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    assign mask_hit    = done_mask | (core_end & en_q);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

    // Next-state and datapath control.
    // In RUN, completion is tested before timeout, so DONE wins a tie.
    always_comb begin
        state_n   = state;
        en_n      = en_q;
        mask_n    = done_mask;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE, DONE, TIMEOUT: begin
                if (launch_go) begin
                    state_n   = LAUNCH;
                    en_n      = core_enable;
                    mask_n    = '0;
                    cnt_clear = 1'b1;
                end
            end
            LAUNCH: begin
                state_n = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                mask_n = mask_hit;
                if (mask_hit == en_q) begin
                    state_n = DONE;
                end else if (timeout_hit) begin
                    state_n = TIMEOUT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, captured enables and registered outputs.
    // Outputs are decoded from the next state, so each one lines up with the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            en_q       <= '0;
            done_mask  <= '0;
            core_start <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            start_q    <= start;
            en_q       <= en_n;
            done_mask  <= mask_n;
            core_start <= (state_n == LAUNCH) ? en_n : '0;
            busy       <= (state_n == LAUNCH) || (state_n == RUN);
            done       <= (state_n == DONE);
            timeout    <= (state_n == TIMEOUT);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

`ifdef RUN_CTRL_PERCORE_CNT_EN
    // Each per-core counter runs in step with cycle_count while its core is still pending.
    // On the cycle where the core's end is recorded, done_mask is still clear.
    // The counter therefore includes that cycle and then freezes.
    for (genvar i = 0; i < N_CORES; i++) begin : g_core_cnt
        sat_counter #(.W(CNT_W)) u_core_cnt (
            .clk    (clk),
            .reset  (reset),
            .clear  (cnt_clear || (state == LAUNCH)),
            .enable ((state == RUN) && en_q[i] && !done_mask[i]),
            .count  (core_cycles[i])
        );
    end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl
//   Directed bench for run_ctrl.
//   A main instance (4 cores, 32-bit count, timeout 20) is checked every cycle against a behavioural model.
//   Literal expectations pin each scenario's outcome.
//   A small second instance (1 core, 4-bit count, timeout disabled) covers counter saturation.
//   Under RUN_CTRL_PERCORE_CNT_EN the per-core counters of the first scenario are also checked.
module tb_run_ctrl;

    localparam int  NC   = 4;
    localparam int  CW   = 32;
    localparam int  TO   = 20;
    localparam longint CMAX = (64'd1 << CW) - 1;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DONE   = 3;
    localparam int P_TO     = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NC-1:0] coreEnable;
    logic [NC-1:0] coreEnd;
    logic [NC-1:0] coreStart;
    logic          busy, done, timeout;
    logic [NC-1:0] doneMask;
    logic [CW-1:0] cycleCount;

    logic          sStart, sEnable, sEnd;
    logic          sCoreStart, sBusy, sDone, sTimeout, sMask;
    logic [3:0]    sCount;

`ifdef RUN_CTRL_PERCORE_CNT_EN
    logic [CW-1:0] coreCycles [NC];
    logic [3:0]    sCoreCycles [1];
`endif

    int checks = 0;
    int errors = 0;
    bit cmpOn  = 1'b0;

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    run_ctrl #(.N_CORES(NC), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_enable (coreEnable),
        .core_start  (coreStart),
        .core_end    (coreEnd),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .done_mask   (doneMask),
`ifdef RUN_CTRL_PERCORE_CNT_EN
        .core_cycles (coreCycles),
`endif
        .cycle_count (cycleCount)
    );

    run_ctrl #(.N_CORES(1), .CNT_W(4), .TIMEOUT_CYC(0)) dutSat (
        .clk         (clk),
        .reset       (reset),
        .start       (sStart),
        .core_enable (sEnable),
        .core_start  (sCoreStart),
        .core_end    (sEnd),
        .busy        (sBusy),
        .done        (sDone),
        .timeout     (sTimeout),
        .done_mask   (sMask),
`ifdef RUN_CTRL_PERCORE_CNT_EN
        .core_cycles (sCoreCycles),
`endif
        .cycle_count (sCount)
    );

    // One comparison: bump the counters and report any difference.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model of one run.
    // It tracks the phase, the captured enables, the finished cores and the elapsed cycles.
    // The elapsed cycle count is plain saturating arithmetic.
    int            mPhase   = P_IDLE;
    logic          mStartQ  = 1'b0;
    logic [NC-1:0] mEn      = '0;
    logic [NC-1:0] mMask    = '0;
    longint        mCount   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mPhase  <= P_IDLE;
            mStartQ <= 1'b0;
            mEn     <= '0;
            mMask   <= '0;
            mCount  <= 0;
        end else begin
            mStartQ <= start;
            if (mPhase == P_LAUNCH) begin
                mPhase <= P_RUN;
            end else if (mPhase == P_RUN) begin
                mCount <= (mCount + 1 > CMAX) ? CMAX : mCount + 1;
                mMask  <= mMask | (coreEnd & mEn);
                if ((mMask | (coreEnd & mEn)) == mEn)
                    mPhase <= P_DONE;
                else if (TO != 0 && mCount + 1 == TO)
                    mPhase <= P_TO;
            end else if (start && !mStartQ && coreEnable != '0) begin
                mPhase <= P_LAUNCH;
                mEn    <= coreEnable;
                mMask  <= '0;
                mCount <= 0;
            end
        end
    end

    // Compare every output of the main instance with the model, just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (cmpOn) begin
            checkOutput("model core_start", coreStart, (mPhase == P_LAUNCH) ? mEn : '0);
            checkOutput("model busy", busy, (mPhase == P_LAUNCH) || (mPhase == P_RUN));
            checkOutput("model done", done, mPhase == P_DONE);
            checkOutput("model timeout", timeout, mPhase == P_TO);
            checkOutput("model done_mask", doneMask, mMask);
            checkOutput("model cycle_count", cycleCount, mCount);
        end
    end

    // Launch a run on the main instance and pulse each core's end in its given RUN cycle.
    // An end cycle of 0 means that core never ends.
    // The task returns at the falling edge inside RUN cycle n+1.
    task automatic applyStimulus(input logic [NC-1:0] en, input int e0, input int e1,
                                 input int e2, input int e3, input int n);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        coreEnable = en;
        @(negedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            coreEnd = {1'(e3 == c), 1'(e2 == c), 1'(e1 == c), 1'(e0 == c)};
        end
        @(negedge clk);
        coreEnd = '0;
    endtask

    // Directed scenarios, each followed by literal checks of its final outcome.
    initial begin
        int pulses;
        start      = 1'b0;
        coreEnable = '0;
        coreEnd    = '0;
        sStart     = 1'b0;
        sEnable    = 1'b0;
        sEnd       = 1'b0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        repeat (2) @(negedge clk);
        cmpOn = 1'b1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset core_start", coreStart, 0);
        checkOutput("reset cycle_count", cycleCount, 0);
        reset = 1'b1;

        // All four cores end in RUN cycles 5, 7, 7 and 12.
        applyStimulus(4'b1111, 5, 7, 7, 12, 14);
        checkOutput("c1 done", done, 1);
        checkOutput("c1 done_mask", doneMask, 4'b1111);
        checkOutput("c1 cycle_count", cycleCount, 12);
        checkOutput("c1 busy", busy, 0);
`ifdef RUN_CTRL_PERCORE_CNT_EN
        checkOutput("c1 core_cycles0", coreCycles[0], 5);
        checkOutput("c1 core_cycles1", coreCycles[1], 7);
        checkOutput("c1 core_cycles2", coreCycles[2], 7);
        checkOutput("c1 core_cycles3", coreCycles[3], 12);
`endif

        // Start stays high through DONE and must not relaunch.
        repeat (4) @(negedge clk);
        checkOutput("c5 held done", done, 1);
        checkOutput("c5 held count", cycleCount, 12);

        // Dropping and raising start gives exactly one launch pulse.
        // The count restarts from zero.
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (coreStart != '0) pulses++;
            if (i == 0) checkOutput("c5 launch count", cycleCount, 0);
        end
        checkOutput("c5 launch pulses", pulses, 1);
        repeat (20) @(negedge clk);
        checkOutput("c5 idle run timeout", timeout, 1);

        // A pulse on disabled core 1 must not be recorded.
        applyStimulus(4'b0101, 4, 3, 6, 0, 8);
        checkOutput("c2 done", done, 1);
        checkOutput("c2 done_mask", doneMask, 4'b0101);
        checkOutput("c2 cycle_count", cycleCount, 6);

        // Core 3 never ends, so the run times out at 20.
        applyStimulus(4'b1111, 3, 5, 8, 0, 24);
        checkOutput("c3 timeout", timeout, 1);
        checkOutput("c3 done", done, 0);
        checkOutput("c3 done_mask", doneMask, 4'b0111);
        checkOutput("c3 cycle_count", cycleCount, 20);

        // The last core ends exactly on the timeout cycle; completion wins.
        applyStimulus(4'b1111, 2, 4, 6, 20, 22);
        checkOutput("c4 done", done, 1);
        checkOutput("c4 timeout", timeout, 0);
        checkOutput("c4 cycle_count", cycleCount, 20);

        // Reset in RUN cycle 5 clears every output at once.
        // Releasing it with start high relaunches on the first edge.
        applyStimulus(4'b1111, 0, 0, 0, 0, 4);
        reset = 1'b0;
        #1;
        checkOutput("c6 reset busy", busy, 0);
        checkOutput("c6 reset core_start", coreStart, 0);
        checkOutput("c6 reset cycle_count", cycleCount, 0);
        checkOutput("c6 reset done_mask", doneMask, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("c6 relaunch core_start", coreStart, 4'b1111);
        checkOutput("c6 relaunch busy", busy, 1);
        repeat (25) @(negedge clk);
        checkOutput("c6 final timeout", timeout, 1);

        // 4-bit counter with timeout disabled: saturates at 15 and never times out.
        sStart  = 1'b1;
        sEnable = 1'b1;
        repeat (22) @(negedge clk);
        checkOutput("sat count", sCount, 15);
        checkOutput("sat busy", sBusy, 1);
        checkOutput("sat timeout", sTimeout, 0);
        sEnd = 1'b1;
        @(negedge clk);
        sEnd = 1'b0;
        @(negedge clk);
        checkOutput("sat done", sDone, 1);
        checkOutput("sat done_mask", sMask, 1);
        checkOutput("sat final count", sCount, 15);

        cmpOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
